mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one mem_system instance between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the two pipeline stages and the cache. It forwards one requester's Rd/Wr/Addr/DataIn, holds that grant until the cache reports Done, and returns data plus a per-requester stall to the hazard logic.
- Default priority goes to the data port, because it serves the older instruction. A starvation counter guarantees fetch progress.

Parameters:
- AW, 16, address width
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive data-port wins (fetch pending) before fetch is forced priority; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  master reset, asynchronous, active high
- if_rd  in  1  fetch read request, held until if_done
- if_addr  in  AW  fetch address
- if_data  out  DW  fetch read data, valid when if_done
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  fetch must hold (if_rd & ~if_done)
- dm_rd  in  1  data read request, held until dm_done
- dm_wr  in  1  data write request, held until dm_done
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_data  out  DW  data read result, valid when dm_done
- dm_done  out  1  one-cycle completion pulse to memory stage
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_rd  out  1  to cache Rd
- mem_wr  out  1  to cache Wr
- mem_addr  out  AW  to cache Addr
- mem_wdata  out  DW  to cache DataIn
- mem_dout  in  DW  cache DataOut
- mem_done  in  1  cache Done
- mem_err  in  1  cache err
- err  out  1  arbiter/cache error

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- States: IDLE, GNT_D, GNT_I. Reset goes to IDLE and clears starve_cnt to 0. All outputs are 0 in reset/IDLE with no request.
- IDLE arbitration (combinational, same cycle):
  - winner = I if if_rd & (~dmreq | starve_cnt==STARVE_LIMIT).
  - Otherwise winner = D if dmreq = dm_rd|dm_wr.
  - Otherwise no winner.
  - The winner's signals drive mem_* in that same cycle (zero-latency issue).
- IDLE transitions:
  - Winner with mem_done=0: go to GNT_<winner>.
  - Winner with mem_done=1 (hit completing same cycle): pulse the winner's done and stay IDLE.
- GNT_x:
  - mem_* driven from requester x only; the other requester's inputs are ignored.
  - On mem_done: pulse done_x, route mem_dout to x_data, return to IDLE.
  - No back-to-back issue: the IDLE cycle re-arbitrates.
- Grant lock: a granted request is never preempted. A requester dropping its request while granted raises err and returns to IDLE.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - Increments when D wins in IDLE while if_rd=1.
  - Clears when I wins or when if_rd=0 in IDLE.
- Non-granted data outputs hold 0. if_data and dm_data are 0 unless the matching done is 1.
- err is combinational OR of:
  - mem_err while granted
  - dm_rd&dm_wr
  - misaligned access (address bit0=1 with a request)
  - grant drop
- Misaligned requests are not forwarded: mem_rd=mem_wr=0 for that requester, and no grant is taken.
- Reset mid-transaction: state returns to IDLE immediately and mem_rd/mem_wr drop asynchronously. The requester's done never pulses; the pipeline is also reset.
- Simultaneous mem_done and new request in GNT_x: the new request waits for IDLE (1-cycle bubble).

Decomposition:
- Shared package: state encoding (IDLE=2'b00, GNT_D=2'b01, GNT_I=2'b10) and a GRANT_D/GRANT_I constant pair.
- One natural sub-module: starve_counter (saturating up-counter with clear, parameterized limit).
- The mux/FSM stays in the top.

Test Plan:
- Fetch-only read: if_rd=1, if_addr=16'h0040, mem_done after 3 cycles with mem_dout=16'hA5A5 -> if_stall=1 for 3 cycles, if_done pulse with if_data=16'hA5A5, state back to IDLE.
- Contention: if_rd and dm_wr both asserted in IDLE, dm_addr=16'h1000 -> mem_wr=1, mem_addr=16'h1000. Fetch stalls until dm_done, then fetch is issued on the next IDLE cycle.
- Starvation: dm_rd held continuously with fetch pending, STARVE_LIMIT=4 -> after 4 data grants, the 5th IDLE cycle grants fetch even though dm_rd=1; starve_cnt clears.
- Same-cycle hit: dm_rd=1 with mem_done=1 in IDLE -> dm_done pulses that cycle and the FSM never enters GNT_D.
- Errors: dm_addr=16'h0003 with dm_rd=1 -> err=1, mem_rd=0. mem_err=1 during GNT_I -> err=1.
- Async reset in GNT_D mid-miss -> mem_wr falls before the next clk edge, state=IDLE, starve_cnt=0, no dm_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_D = 2'b01,
    GNT_I = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_D    = 2'b01,
    GRANT_I    = 2'b10
  } grant_e;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and cache-side handshake signals.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_rd;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_data;
  logic          if_done;
  logic          if_stall;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_data;
  logic          dm_done;
  logic          dm_stall;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_dout;
  logic          mem_done;
  logic          mem_err;

  logic          err;

  // Arbiter side
  modport slave (
    input  if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
           mem_dout, mem_done, mem_err,
    output if_data, if_done, if_stall, dm_data, dm_done, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_wdata, err
  );

  // Pipeline/cache side
  modport master (
    output if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
           mem_dout, mem_done, mem_err,
    input  if_data, if_done, if_stall, dm_data, dm_done, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter with clear; tracks consecutive data-port wins.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_i,
  input  logic                    clr_i,
  output logic [STARVE_CNT_W-1:0] cnt_o,
  output logic                    sat_o
);
  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != LIM))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between fetch (reads) and data (reads/writes).
// Data wins by default; a starvation counter forces fetch through.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e              state_q, state_d;
  grant_e                  sel;
  logic                    dm_req, if_ok, dm_ok;
  logic                    win_i, win_d, drop;
  logic                    starve_sat, cnt_inc, cnt_clr;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  // Request qualification and IDLE-cycle priority decision
  always_comb begin
    dm_req = bus.dm_rd | bus.dm_wr;
    if_ok  = bus.if_rd & ~bus.if_addr[0];
    // A simultaneous read+write is flagged and, like a misaligned access, never forwarded
    dm_ok  = dm_req & ~bus.dm_addr[0] & ~(bus.dm_rd & bus.dm_wr);
    win_i  = if_ok & (~dm_ok | starve_sat);
    win_d  = dm_ok & ~win_i;
  end

  // Next state, current grant selection and grant-drop detection
  always_comb begin
    state_d = state_q;
    sel     = GRANT_NONE;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_i)      sel = GRANT_I;
        else if (win_d) sel = GRANT_D;
        if ((win_i | win_d) & ~bus.mem_done)
          state_d = win_i ? GNT_I : GNT_D;
      end
      GNT_D: begin
        sel  = GRANT_D;
        drop = ~dm_req;
        if (drop | bus.mem_done) state_d = IDLE;
      end
      GNT_I: begin
        sel  = GRANT_I;
        drop = ~bus.if_rd;
        if (drop | bus.mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Cache-side mux, completion routing and error reporting; all gated by reset
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_done   = 1'b0;
    bus.if_data   = '0;
    bus.dm_done   = 1'b0;
    bus.dm_data   = '0;
    case (sel)
      GRANT_D: begin
        bus.mem_rd    = bus.dm_rd;
        bus.mem_wr    = bus.dm_wr;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
        bus.dm_done   = bus.mem_done & ~drop;
        bus.dm_data   = bus.dm_done ? bus.mem_dout : '0;
      end
      GRANT_I: begin
        bus.mem_rd    = bus.if_rd;
        bus.mem_addr  = bus.if_addr;
        bus.if_done   = bus.mem_done & ~drop;
        bus.if_data   = bus.if_done ? bus.mem_dout : '0;
      end
      default: ;
    endcase
    bus.if_stall = bus.if_rd & ~bus.if_done;
    bus.dm_stall = dm_req & ~bus.dm_done;
    bus.err      = ((sel != GRANT_NONE) & bus.mem_err)
                 | (bus.dm_rd & bus.dm_wr)
                 | (bus.if_rd & bus.if_addr[0])
                 | (dm_req & bus.dm_addr[0])
                 | drop;
    if (rst) begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.if_done   = 1'b0;
      bus.if_data   = '0;
      bus.dm_done   = 1'b0;
      bus.dm_data   = '0;
      bus.if_stall  = 1'b0;
      bus.dm_stall  = 1'b0;
      bus.err       = 1'b0;
    end
  end

  // Grant state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Starvation tracking only moves on IDLE arbitration cycles
  always_comb begin
    cnt_inc = (state_q == IDLE) & win_d & bus.if_rd;
    cnt_clr = (state_q == IDLE) & (win_i | ~bus.if_rd);
  end

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (starve_cnt),
    .sat_o (starve_sat)
  );

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed sequences, random traffic.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 4;

  localparam int OWN_NONE = 0;
  localparam int OWN_D    = 1;
  localparam int OWN_I    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        if_rd;
    logic [15:0] if_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] mem_dout;
    logic        mem_done;
    logic        mem_err;
  } in_t;

  typedef struct packed {
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        if_done;
    logic [15:0] if_data;
    logic        if_stall;
    logic        dm_done;
    logic [15:0] dm_data;
    logic        dm_stall;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  in_t  cur;
  out_t last_act, last_exp;
  int   m_owner, m_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic in_t mk_in(logic ir, logic [15:0] ia, logic dr, logic dw,
                                logic [15:0] da, logic [15:0] wd, logic [15:0] dout,
                                logic md, logic me);
    in_t v;
    v.if_rd = ir; v.if_addr = ia; v.dm_rd = dr; v.dm_wr = dw; v.dm_addr = da;
    v.dm_wdata = wd; v.mem_dout = dout; v.mem_done = md; v.mem_err = me;
    return v;
  endfunction

  function automatic out_t mk_out(logic mr, logic mw, logic [15:0] ma, logic [15:0] mwd,
                                  logic ifd, logic [15:0] ifdat, logic ifs,
                                  logic dmd, logic [15:0] dmdat, logic dms, logic e);
    out_t o;
    o.mem_rd = mr; o.mem_wr = mw; o.mem_addr = ma; o.mem_wdata = mwd;
    o.if_done = ifd; o.if_data = ifdat; o.if_stall = ifs;
    o.dm_done = dmd; o.dm_data = dmdat; o.dm_stall = dms; o.err = e;
    return o;
  endfunction

  task automatic set(input in_t v);
    cur          = v;
    bus.if_rd    = v.if_rd;
    bus.if_addr  = v.if_addr;
    bus.dm_rd    = v.dm_rd;
    bus.dm_wr    = v.dm_wr;
    bus.dm_addr  = v.dm_addr;
    bus.dm_wdata = v.dm_wdata;
    bus.mem_dout = v.mem_dout;
    bus.mem_done = v.mem_done;
    bus.mem_err  = v.mem_err;
  endtask

  function automatic out_t sample();
    return mk_out(bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                  bus.if_done, bus.if_data, bus.if_stall,
                  bus.dm_done, bus.dm_data, bus.dm_stall, bus.err);
  endfunction

  // Reference: who owns the cache port this cycle, and whether the owner walked away
  function automatic int model_pick(input in_t v, output logic drop);
    logic dreq, dlegal, ilegal;
    dreq   = v.dm_rd | v.dm_wr;
    dlegal = dreq && !v.dm_addr[0] && !(v.dm_rd && v.dm_wr);
    ilegal = v.if_rd && !v.if_addr[0];
    drop   = 1'b0;
    if (m_owner != OWN_NONE) begin
      drop = (m_owner == OWN_D) ? !dreq : !v.if_rd;
      return m_owner;
    end
    if (ilegal && (!dlegal || m_cnt == LIM)) return OWN_I;
    if (dlegal) return OWN_D;
    return OWN_NONE;
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o;
    logic drop;
    int   who;
    o   = '0;
    who = model_pick(v, drop);
    if (who == OWN_D) begin
      o.mem_rd = v.dm_rd; o.mem_wr = v.dm_wr;
      o.mem_addr = v.dm_addr; o.mem_wdata = v.dm_wdata;
      if (v.mem_done && !drop) begin o.dm_done = 1'b1; o.dm_data = v.mem_dout; end
    end else if (who == OWN_I) begin
      o.mem_rd = v.if_rd; o.mem_addr = v.if_addr;
      if (v.mem_done && !drop) begin o.if_done = 1'b1; o.if_data = v.mem_dout; end
    end
    o.if_stall = v.if_rd && !o.if_done;
    o.dm_stall = (v.dm_rd || v.dm_wr) && !o.dm_done;
    o.err = (who != OWN_NONE && v.mem_err) || (v.dm_rd && v.dm_wr) ||
            (v.if_rd && v.if_addr[0]) || ((v.dm_rd || v.dm_wr) && v.dm_addr[0]) || drop;
    return o;
  endfunction

  function automatic void model_next(input in_t v);
    logic drop;
    int   who;
    who = model_pick(v, drop);
    if (m_owner == OWN_NONE) begin
      if (!v.if_rd || who == OWN_I) m_cnt = 0;
      else if (who == OWN_D && m_cnt < LIM) m_cnt++;
      m_owner = (who != OWN_NONE && !v.mem_done) ? who : OWN_NONE;
    end else if (drop || v.mem_done) begin
      m_owner = OWN_NONE;
    end
  endfunction

  task automatic step(input string name);
    @(negedge clk);
    last_exp = model_out(cur);
    last_act = sample();
    chk(name, last_act, last_exp);
    @(posedge clk);
    model_next(cur);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_owner = OWN_NONE;
    m_cnt   = 0;
  endtask

  vec_t tbl[12];

  initial begin
    in_t  v;
    int   stalls;
    logic f_act, d_act;

    tbl[0]  = '{i: mk_in(0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,0,0),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0)};
    tbl[1]  = '{i: mk_in(1,16'h0040,0,0,16'h0000,16'h0000,16'h0000,0,0),
                o: mk_out(1,0,16'h0040,16'h0000,0,16'h0000,1,0,16'h0000,0,0)};
    tbl[2]  = '{i: mk_in(1,16'h0040,0,0,16'h0000,16'h0000,16'hA5A5,1,0),
                o: mk_out(1,0,16'h0040,16'h0000,1,16'hA5A5,0,0,16'h0000,0,0)};
    tbl[3]  = '{i: mk_in(1,16'h0080,0,1,16'h1000,16'h1234,16'h0000,0,0),
                o: mk_out(0,1,16'h1000,16'h1234,0,16'h0000,1,0,16'h0000,1,0)};
    tbl[4]  = '{i: mk_in(0,16'h0000,1,0,16'h0200,16'h0000,16'hBEEF,1,0),
                o: mk_out(1,0,16'h0200,16'h0000,0,16'h0000,0,1,16'hBEEF,0,0)};
    tbl[5]  = '{i: mk_in(0,16'h0000,1,0,16'h0003,16'h0000,16'h0000,0,0),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,1,1)};
    tbl[6]  = '{i: mk_in(0,16'h0000,1,1,16'h0010,16'h0000,16'h0000,0,0),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,1,1)};
    tbl[7]  = '{i: mk_in(0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,0,1),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0)};
    tbl[8]  = '{i: mk_in(0,16'h0000,1,0,16'h0004,16'h0000,16'h0000,0,1),
                o: mk_out(1,0,16'h0004,16'h0000,0,16'h0000,0,0,16'h0000,1,1)};
    tbl[9]  = '{i: mk_in(1,16'h0041,1,0,16'h0008,16'h0000,16'h0000,0,0),
                o: mk_out(1,0,16'h0008,16'h0000,0,16'h0000,1,0,16'h0000,1,1)};
    tbl[10] = '{i: mk_in(1,16'h0041,0,0,16'h0000,16'h0000,16'h0000,1,0),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,1,0,16'h0000,0,1)};
    tbl[11] = '{i: mk_in(0,16'h0000,0,0,16'h0000,16'h0000,16'h1111,1,0),
                o: mk_out(0,0,16'h0000,16'h0000,0,16'h0000,0,0,16'h0000,0,0)};

    // Outputs held at zero while reset is asserted, even with requests present
    set(mk_in(1,16'h0040,1,0,16'h0200,16'h0000,16'hFFFF,1,1));
    #2;
    chk("reset_outputs", sample(), '0);

    // Single-cycle vectors, each from a fresh IDLE state
    for (int k = 0; k < 12; k++) begin
      do_reset();
      set(tbl[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d", k), sample(), tbl[k].o);
      @(posedge clk);
      #1;
    end

    // Fetch-only read completing after three wait cycles
    do_reset();
    v = '0; v.if_rd = 1'b1; v.if_addr = 16'h0040; v.mem_dout = 16'hA5A5;
    set(v);
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      step("fetch_wait");
      if (last_act.if_stall) stalls++;
    end
    v.mem_done = 1'b1; set(v);
    step("fetch_done");
    chk("fetch_done_pulse", last_act.if_done, 1);
    chk("fetch_data", last_act.if_data, 16'hA5A5);
    chk("fetch_stall_cycles", stalls, 3);
    v = '0; set(v);
    step("fetch_idle");
    chk("fetch_idle_memrd", last_act.mem_rd, 0);

    // Contention: data write wins, fetch follows on the next IDLE cycle
    do_reset();
    v = '0; v.if_rd = 1'b1; v.if_addr = 16'h0080;
    v.dm_wr = 1'b1; v.dm_addr = 16'h1000; v.dm_wdata = 16'h5A5A;
    set(v);
    step("cont_issue");
    chk("cont_memwr", last_act.mem_wr, 1);
    chk("cont_memaddr", last_act.mem_addr, 16'h1000);
    v.mem_done = 1'b1; set(v);
    step("cont_dm_done");
    chk("cont_dm_done_pulse", last_act.dm_done, 1);
    chk("cont_bubble_memrd", last_act.mem_rd, 0);
    chk("cont_fetch_stalled", last_act.if_stall, 1);
    v.dm_wr = 1'b0; v.mem_done = 1'b0; set(v);
    step("cont_fetch_issue");
    chk("cont_fetch_addr", last_act.mem_addr, 16'h0080);
    chk("cont_fetch_rd", last_act.mem_rd, 1);
    v.mem_done = 1'b1; v.mem_dout = 16'h1111; set(v);
    step("cont_fetch_done");
    chk("cont_if_done", last_act.if_done, 1);

    // Starvation: four data grants, then fetch is forced through
    do_reset();
    v = '0; v.if_rd = 1'b1; v.if_addr = 16'h0100; v.dm_rd = 1'b1; v.dm_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      v.mem_done = 1'b0; set(v);
      step("starve_d_issue");
      chk("starve_d_addr", last_act.mem_addr, 16'h0200);
      v.mem_done = 1'b1; set(v);
      step("starve_d_done");
    end
    v.mem_done = 1'b0; set(v);
    step("starve_i_issue");
    chk("starve_forced_fetch", last_act.mem_addr, 16'h0100);
    v.mem_done = 1'b1; set(v);
    step("starve_i_done");
    chk("starve_if_done", last_act.if_done, 1);
    v.mem_done = 1'b0; set(v);
    step("starve_after_clear");
    chk("starve_cleared_d_wins", last_act.mem_addr, 16'h0200);
    v.mem_done = 1'b1; set(v);
    step("starve_final_done");

    // Same-cycle hit never enters the grant state
    do_reset();
    v = '0; v.dm_rd = 1'b1; v.dm_addr = 16'h0300; v.mem_dout = 16'hCAFE; v.mem_done = 1'b1;
    set(v);
    step("hit_same_cycle");
    chk("hit_dm_done", last_act.dm_done, 1);
    chk("hit_dm_data", last_act.dm_data, 16'hCAFE);
    v = '0; set(v);
    step("hit_after");
    chk("hit_no_drop_err", last_act.err, 0);

    // mem_err while fetch holds the grant
    do_reset();
    v = '0; v.if_rd = 1'b1; v.if_addr = 16'h0400; set(v);
    step("merr_issue");
    v.mem_err = 1'b1; set(v);
    step("merr_gnt_i");
    chk("merr_err", last_act.err, 1);
    v.mem_err = 1'b0; v.mem_done = 1'b1; set(v);
    step("merr_done");
    v = '0; set(v);
    step("merr_idle");

    // Data requester drops its request while granted
    do_reset();
    v = '0; v.dm_rd = 1'b1; v.dm_addr = 16'h0500; set(v);
    step("drop_issue");
    v.dm_rd = 1'b0; set(v);
    step("drop_cycle");
    chk("drop_err", last_act.err, 1);
    chk("drop_no_done", last_act.dm_done, 0);
    step("drop_idle");
    chk("drop_idle_err", last_act.err, 0);

    // Asynchronous reset in the middle of a data-write miss
    do_reset();
    v = '0; v.dm_wr = 1'b1; v.dm_addr = 16'h0600; v.dm_wdata = 16'h7777; set(v);
    step("ar_issue");
    chk("ar_memwr_before", bus.mem_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_memwr_async_drop", bus.mem_wr, 0);
    chk("ar_no_dm_done", bus.dm_done, 0);
    set('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_owner = OWN_NONE;
    m_cnt   = 0;
    step("ar_after");

    // Random well-behaved requesters with occasional misalignment and drops
    do_reset();
    v = '0; f_act = 1'b0; d_act = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!f_act && $urandom_range(99) < 35) begin
        f_act = 1'b1; v.if_rd = 1'b1; v.if_addr = 16'($urandom);
        v.if_addr[0] = ($urandom_range(99) < 5);
      end
      if (!d_act && $urandom_range(99) < 35) begin
        d_act = 1'b1;
        v.dm_rd = ($urandom_range(1) == 0); v.dm_wr = !v.dm_rd;
        v.dm_addr = 16'($urandom); v.dm_addr[0] = ($urandom_range(99) < 5);
        v.dm_wdata = 16'($urandom);
      end
      v.mem_done = ($urandom_range(99) < 40);
      v.mem_err  = ($urandom_range(99) < 5);
      v.mem_dout = 16'($urandom);
      set(v);
      step("rand");
      if (f_act && (last_exp.if_done || (v.if_addr[0] && $urandom_range(99) < 30) ||
                    $urandom_range(99) < 2)) begin
        f_act = 1'b0; v.if_rd = 1'b0;
      end
      if (d_act && (last_exp.dm_done || (v.dm_addr[0] && $urandom_range(99) < 30) ||
                    $urandom_range(99) < 2)) begin
        d_act = 1'b0; v.dm_rd = 1'b0; v.dm_wr = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
